serial_deser: RTL and testbench

//  Serial-to-parallel deserializer: collects WIDTH serial bits, presents the word on a

---
 rtl/deser_pkg.sv | 22 ++
 rtl/ms_dff.sv | 44 ++++
 rtl/serial_deser.sv | 134 +++++++++++++
 tb/tb_serial_deser.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// ---------------------------------------------------------------------------
// deser_pkg
//   Shared types and helpers for the serial deserializer.
//   - out_state_t : output-stage FSM state (EMPTY = no word held, FULL = word
//                   held and not yet consumed). EMPTY encodes as 0 so that a
//                   cleared flop naturally means "empty".
//   - deser_cnt_w : width of the bit counter, wide enough to hold 0..width.
// ---------------------------------------------------------------------------
package deser_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    localparam int DESER_DEFAULT_WIDTH = 8;

    function automatic int deser_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/ms_dff.sv
// ---------------------------------------------------------------------------
// ms_dff
//   One-bit rising-edge flop built from two opposite-phase D latches.
//   The master latch is transparent while the clock is low and closes on the
//   rising edge; the slave latch is transparent while the clock is high and
//   passes the value the master captured. Net effect: o_q takes i_d as it was
//   just before the rising edge.
//   Synchronous reset is applied by forcing the data input to 0 while i_r is
//   high, so reset takes effect only at a rising edge.
//
// Ports
//   i_clk : clock
//   i_r   : synchronous reset, active-high
//   i_d   : data in
//   o_q   : data out (changes only after a rising edge)
// ---------------------------------------------------------------------------
module ms_dff (
    input  logic i_clk,
    input  logic i_r,
    input  logic i_d,
    output logic o_q
);

    logic w_d;
    logic r_master;
    logic r_slave;

    assign w_d = i_d & ~i_r;

    always_latch begin
        if (!i_clk) begin
            r_master <= w_d;
        end
    end

    always_latch begin
        if (i_clk) begin
            r_slave <= r_master;
        end
    end

    assign o_q = r_slave;

endmodule

// File: rtl/serial_deser.sv
// ---------------------------------------------------------------------------
// serial_deser
//   Serial-to-parallel deserializer. Collects WIDTH serial bits (LSB first)
//   and offers the assembled word on a valid/ready parallel port. The serial
//   side is never stalled: a word that completes while the previous one is
//   still unconsumed is dropped and Overrun is set (sticky until reset).
//
//   Handshake: a word is transferred on a rising edge where ParValid and
//   ParReady are both high. ParValid stays high and ParOut stays stable until
//   that transfer; ParReady while ParValid is low has no effect.
//
//   All state lives in ms_dff instances; this module only holds the
//   combinational next-state logic, so every output comes straight from a flop.
//
// Ports
//   Clk         : clock, all state changes on the rising edge
//   R           : synchronous reset, active-high (discards any partial word)
//   SerIn       : serial data bit
//   SerValid    : SerIn is consumed on this edge
//   ParOut      : assembled word, bit 0 = first bit received
//   ParValid    : ParOut holds an unconsumed word
//   ParReady    : consumer accepts ParOut
//   BitCnt      : number of bits collected in the current word
//   Overrun     : sticky flag, a completed word was dropped
//   o_dbg_state : current output FSM state (debug visibility)
// ---------------------------------------------------------------------------
module serial_deser
    import deser_pkg::*;
#(
    parameter  int WIDTH = DESER_DEFAULT_WIDTH,
    localparam int CNT_W = deser_cnt_w(WIDTH)
) (
    input  logic             Clk,
    input  logic             R,
    input  logic             SerIn,
    input  logic             SerValid,
    output logic [WIDTH-1:0] ParOut,
    output logic             ParValid,
    input  logic             ParReady,
    output logic [CNT_W-1:0] BitCnt,
    output logic             Overrun,
    output out_state_t       o_dbg_state
);

    // Every state bit of the block, packed so one generate loop can map each
    // bit onto its own master-slave flop.
    typedef struct packed {
        logic             ovr;
        out_state_t       st;
        logic [WIDTH-1:0] par;
        logic [CNT_W-1:0] cnt;
        logic [WIDTH-1:0] sreg;
    } deser_state_t;

    localparam int ST_W = $bits(deser_state_t);

    deser_state_t    w_cur;
    deser_state_t    w_nxt;
    logic [ST_W-1:0] w_q_bits;
    logic [ST_W-1:0] w_d_bits;

    logic [WIDTH-1:0] w_word;
    logic             w_complete;

    // -----------------------------------------------------------------------
    // State storage
    // -----------------------------------------------------------------------
    genvar g;
    generate
        for (g = 0; g < ST_W; g++) begin : g_state_ff
            ms_dff u_ff (
                .i_clk (Clk),
                .i_r   (R),
                .i_d   (w_d_bits[g]),
                .o_q   (w_q_bits[g])
            );
        end
    endgenerate

    assign w_cur    = deser_state_t'(w_q_bits);
    assign w_d_bits = ST_W'(w_nxt);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // The word as it will look after this bit is shifted in; used both as the
    // next shift-register value and, on completion, as the outgoing word.
    assign w_word     = {SerIn, w_cur.sreg[WIDTH-1:1]};
    assign w_complete = SerValid && (w_cur.cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_nxt = w_cur;

        if (SerValid) begin
            w_nxt.sreg = w_word;
            w_nxt.cnt  = w_complete ? '0 : w_cur.cnt + CNT_W'(1);
        end

        case (w_cur.st)
            EMPTY: begin
                if (w_complete) begin
                    w_nxt.st  = FULL;
                    w_nxt.par = w_word;
                end
            end
            FULL: begin
                if (w_complete) begin
                    // Back-to-back when the consumer takes the old word on the
                    // same edge; otherwise the new word has nowhere to go.
                    if (ParReady) begin
                        w_nxt.par = w_word;
                    end else begin
                        w_nxt.ovr = 1'b1;
                    end
                end else if (ParReady) begin
                    w_nxt.st = EMPTY;
                end
            end
            default: begin
                w_nxt.st = EMPTY;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs (all directly from flops)
    // -----------------------------------------------------------------------
    assign ParOut      = w_cur.par;
    assign ParValid    = (w_cur.st == FULL);
    assign BitCnt      = w_cur.cnt;
    assign Overrun     = w_cur.ovr;
    assign o_dbg_state = w_cur.st;

endmodule

// File: tb/tb_serial_deser.sv
module tb_serial_deser;
  import deser_pkg::*;

  localparam int W     = 8;
  localparam int CW    = 4;
  localparam int T_HALF = 5;

  // ---------------- clock / reset block ----------------
  logic          Clk = 1'b0;
  logic          R = 1'b0;
  logic          SerIn = 1'b0;
  logic          SerValid = 1'b0;
  logic          ParReady = 1'b0;
  logic [W-1:0]  ParOut;
  logic          ParValid;
  logic [CW-1:0] BitCnt;
  logic          Overrun;
  out_state_t    dbg_state;

  always #T_HALF Clk = ~Clk;

  serial_deser #(.WIDTH(W)) dut (
    .Clk         (Clk),
    .R           (R),
    .SerIn       (SerIn),
    .SerValid    (SerValid),
    .ParOut      (ParOut),
    .ParValid    (ParValid),
    .ParReady    (ParReady),
    .BitCnt      (BitCnt),
    .Overrun     (Overrun),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  bit sb_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: apply inputs, let one rising edge consume them,
  // return at the next falling edge with outputs settled.
  task automatic drive(input logic r, input logic si, input logic sv, input logic pr);
    R        = r;
    SerIn    = si;
    SerValid = sv;
    ParReady = pr;
    if (sb_en && !r && ParValid && pr) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_accept", 32'(ParOut), 32'hFFFF_FFFF);
      end else begin
        check("sb_accept_word", 32'(ParOut), 32'(exp_q.pop_front()));
      end
    end
    @(negedge Clk);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Shift a full word LSB first; ParReady is asserted only on the last bit.
  task automatic send_word(input logic [W-1:0] w, input logic ready_last);
    for (int i = 0; i < W; i++) begin
      drive(1'b0, w[i], 1'b1, (i == W - 1) ? ready_last : 1'b0);
    end
  endtask

  task automatic check_outs(input string tag, input logic [W-1:0] ep, input logic ev,
                            input logic [CW-1:0] ec, input logic eo);
    check({tag, "_parout"},  32'(ParOut),    32'(ep));
    check({tag, "_parvalid"}, 32'(ParValid), 32'(ev));
    check({tag, "_bitcnt"},  32'(BitCnt),    32'(ec));
    check({tag, "_overrun"}, 32'(Overrun),   32'(eo));
    check({tag, "_state"},   32'(dbg_state), 32'(ev ? FULL : EMPTY));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          r;
    logic          si;
    logic          sv;
    logic          pr;
    logic [W-1:0]  ep;
    logic          ev;
    logic [CW-1:0] ec;
    logic          eo;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic si, input logic sv, input logic pr,
                              input logic [W-1:0] ep, input logic ev,
                              input logic [CW-1:0] ec, input logic eo);
    vec_t v;
    v.r = r; v.si = si; v.sv = sv; v.pr = pr;
    v.ep = ep; v.ev = ev; v.ec = ec; v.eo = eo;
    return v;
  endfunction

  initial begin
    // Reset, then idle.
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 8'h00, 0, 0, 0));
    // 0xA5 = bits 1,0,1,0,0,1,0,1 LSB first, consumer not ready.
    vecs.push_back(mk(0, 1, 1, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 0, 2, 0));
    vecs.push_back(mk(0, 1, 1, 0, 8'h00, 0, 3, 0));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 0, 4, 0));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 0, 5, 0));
    vecs.push_back(mk(0, 1, 1, 0, 8'h00, 0, 6, 0));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 0, 7, 0));
    vecs.push_back(mk(0, 1, 1, 0, 8'hA5, 1, 0, 0));
    // Held while not ready, then accepted; ParOut keeps its last value.
    vecs.push_back(mk(0, 1, 0, 0, 8'hA5, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8'hA5, 0, 0, 0));
    // 0x3C = bits 0,0,1,1,1,1,0,0 with gaps (SerIn=1 during gaps is ignored).
    vecs.push_back(mk(0, 0, 1, 0, 8'hA5, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'hA5, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 8'hA5, 0, 2, 0));
    vecs.push_back(mk(0, 1, 1, 0, 8'hA5, 0, 3, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'hA5, 0, 3, 0));
    vecs.push_back(mk(0, 1, 1, 0, 8'hA5, 0, 4, 0));
    vecs.push_back(mk(0, 1, 1, 0, 8'hA5, 0, 5, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'hA5, 0, 5, 0));
    vecs.push_back(mk(0, 1, 0, 1, 8'hA5, 0, 5, 0));
    vecs.push_back(mk(0, 1, 1, 0, 8'hA5, 0, 6, 0));
    vecs.push_back(mk(0, 0, 1, 0, 8'hA5, 0, 7, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'hA5, 0, 7, 0));
    vecs.push_back(mk(0, 0, 1, 0, 8'h3C, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8'h3C, 0, 0, 0));

    @(negedge Clk);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].si, vecs[i].sv, vecs[i].pr);
      check_outs($sformatf("vec%0d", i), vecs[i].ep, vecs[i].ev, vecs[i].ec, vecs[i].eo);
    end

    sb_en = 1'b1;

    // Back-to-back: 0x11 taken on the same edge 0xF0 completes.
    do_reset();
    send_word(8'h11, 1'b0);
    check_outs("b2b_first", 8'h11, 1, 0, 0);
    exp_q.push_back(8'h11);
    send_word(8'hF0, 1'b1);
    check_outs("b2b_second", 8'hF0, 1, 0, 0);
    exp_q.push_back(8'hF0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check_outs("b2b_drained", 8'hF0, 0, 0, 0);

    // Overrun: 0xF0 completes while 0x11 is still pending and not taken.
    do_reset();
    send_word(8'h11, 1'b0);
    exp_q.push_back(8'h11);
    send_word(8'hF0, 1'b0);
    check_outs("ovr_dropped", 8'h11, 1, 0, 1);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    check_outs("ovr_accepted", 8'h11, 0, 0, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check_outs("ovr_sticky", 8'h11, 0, 0, 1);

    // Reset mid-word discards the partial word; reset beats SerValid.
    do_reset();
    check_outs("mid_after_reset", 8'h00, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b0);
    check("mid_partial_cnt", 32'(BitCnt), 32'd3);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check_outs("mid_reset", 8'h00, 0, 0, 0);
    send_word(8'h5A, 1'b0);
    check_outs("mid_clean_word", 8'h5A, 1, 0, 0);
    exp_q.push_back(8'h5A);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check_outs("mid_drained", 8'h5A, 0, 0, 0);

    check("sb_queue_empty", 32'(exp_q.size()), 32'd0);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
